// File: rtl/vsc8541_smi_pkg.sv
// rtl/vsc8541_smi_pkg.sv - shared states, frame constants and widths for the VSC8541 SMI controller
package vsc8541_smi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_EDGE,
      PREAMBLE,
      HDR,
      TA,
      DATA,
      RELEASE,
      DONE
   } smi_state_t;

   localparam logic [1:0] SMI_ST    = 2'b01;
   localparam logic [1:0] SMI_OP_WR = 2'b01;
   localparam logic [1:0] SMI_OP_RD = 2'b10;
   localparam logic [1:0] SMI_TA_WR = 2'b10;

   localparam int PHYAD_W  = 5;
   localparam int REGAD_W  = 5;
   localparam int DATA_W   = 16;
   localparam int HDR_BITS = 14;

endpackage

// File: rtl/vsc8541_smi_mdc_strobe.sv
// rtl/vsc8541_smi_mdc_strobe.sv - free-running MDC divider with falling-edge and sample strobes
module vsc8541_smi_mdc_strobe #(
   parameter int DIVISOR = 100
) (
   input  logic clk,
   input  logic i_reset_n,
   output logic o_mdc,
   output logic o_fall_stb,
   output logic o_samp_stb
);

   localparam int            CW   = $clog2(DIVISOR);
   localparam logic [CW-1:0] HALF = CW'(DIVISOR >> 1);
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   // MDC is registered from the next count so it always equals (cnt < HALF) without glitches.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt   <= '0;
         o_mdc <= 1'b1;
      end else begin
         cnt   <= cnt_nxt;
         o_mdc <= (cnt_nxt < HALF);
      end
   end

   assign o_fall_stb = (cnt == HALF);
   assign o_samp_stb = (cnt == LAST);

endmodule

// File: rtl/vsc8541_smi_ctrl.sv
// rtl/vsc8541_smi_ctrl.sv - clause 22 MDIO transaction controller: one read or write per request
module vsc8541_smi_ctrl #(
   parameter int DIVISOR      = 100,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [4:0]  i_req_phyad,
   input  logic [4:0]  i_req_regad,
   input  logic [15:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_rdata,
   output logic        o_rsp_ta_err,
   output logic        o_busy,
   output logic        o_mdc,
   output logic        o_mdio_o,
   output logic        o_mdio_oe,
   input  logic        i_mdio_i
);
   import vsc8541_smi_pkg::*;

   localparam logic [5:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;
   localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
   localparam logic [5:0] DAT_LAST = 6'(DATA_W - 1);

   smi_state_t           state, state_nxt;
   logic [5:0]           bit_cnt, bit_cnt_nxt;
   logic                 mdo_nxt, oe_nxt;
   logic                 fall_stb, samp_stb, accept;
   logic                 wr_q, ta_err_q;
   logic [PHYAD_W-1:0]   phyad_q;
   logic [REGAD_W-1:0]   regad_q;
   logic [DATA_W-1:0]    wdata_q, rx_sh;
   logic [HDR_BITS-1:0]  hdr;
   logic [3:0]           hdr_idx, dat_idx;

   vsc8541_smi_mdc_strobe #(.DIVISOR(DIVISOR)) u_mdc (
      .clk        (clk),
      .i_reset_n  (i_reset_n),
      .o_mdc      (o_mdc),
      .o_fall_stb (fall_stb),
      .o_samp_stb (samp_stb)
   );

   assign o_req_ready = (state == IDLE);
   assign o_busy      = (state != IDLE);
   assign accept      = i_req_valid && o_req_ready;
   assign hdr         = {SMI_ST, (wr_q ? SMI_OP_WR : SMI_OP_RD), phyad_q, regad_q};
   // Index of the bit that goes out at the coming fall, one ahead of bit_cnt.
   assign hdr_idx     = 4'(6'(HDR_BITS - 2) - bit_cnt);
   assign dat_idx     = 4'(6'(DATA_W - 2) - bit_cnt);

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         o_mdio_o  <= 1'b1;
         o_mdio_oe <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         o_mdio_o  <= mdo_nxt;
         o_mdio_oe <= oe_nxt;
      end
   end

   // Every drive update is taken on fall_stb, so the pin changes on the following cycle.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      mdo_nxt     = o_mdio_o;
      oe_nxt      = o_mdio_oe;
      case (state)
         IDLE: begin
            if (accept) state_nxt = WAIT_EDGE;
         end
         WAIT_EDGE: begin
            if (fall_stb) begin
               bit_cnt_nxt = '0;
               oe_nxt      = 1'b1;
               if (PREAMBLE_LEN == 0) begin
                  state_nxt = HDR;
                  mdo_nxt   = hdr[HDR_BITS-1];
               end else begin
                  state_nxt = PREAMBLE;
                  mdo_nxt   = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (fall_stb) begin
               if (bit_cnt == PRE_LAST) begin
                  state_nxt   = HDR;
                  bit_cnt_nxt = '0;
                  mdo_nxt     = hdr[HDR_BITS-1];
               end else begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  mdo_nxt     = 1'b1;
               end
            end
         end
         HDR: begin
            if (fall_stb) begin
               if (bit_cnt == HDR_LAST) begin
                  state_nxt   = TA;
                  bit_cnt_nxt = '0;
                  oe_nxt      = wr_q;
                  mdo_nxt     = SMI_TA_WR[1];
               end else begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  mdo_nxt     = hdr[hdr_idx];
               end
            end
         end
         TA: begin
            if (fall_stb) begin
               if (bit_cnt[0]) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
                  mdo_nxt     = wr_q ? wdata_q[DATA_W-1] : 1'b1;
               end else begin
                  bit_cnt_nxt = 6'd1;
                  mdo_nxt     = wr_q ? SMI_TA_WR[0] : 1'b1;
               end
            end
         end
         DATA: begin
            if (fall_stb) begin
               if (bit_cnt == DAT_LAST) begin
                  state_nxt = RELEASE;
                  oe_nxt    = 1'b0;
                  mdo_nxt   = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  mdo_nxt     = wr_q ? wdata_q[dat_idx] : 1'b1;
               end
            end
         end
         RELEASE: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_q         <= 1'b0;
         phyad_q      <= '0;
         regad_q      <= '0;
         wdata_q      <= '0;
         rx_sh        <= '0;
         ta_err_q     <= 1'b0;
         o_rsp_valid  <= 1'b0;
         o_rsp_rdata  <= '0;
         o_rsp_ta_err <= 1'b0;
      end else begin
         o_rsp_valid <= (state == RELEASE);
         if (accept) begin
            wr_q     <= i_req_write;
            phyad_q  <= i_req_phyad;
            regad_q  <= i_req_regad;
            wdata_q  <= i_req_wdata;
            rx_sh    <= '0;
            ta_err_q <= 1'b0;
         end
         if (samp_stb && !wr_q) begin
            if (state == TA && bit_cnt[0]) ta_err_q <= i_mdio_i;
            if (state == DATA)             rx_sh    <= {rx_sh[DATA_W-2:0], i_mdio_i};
         end
         if (state == RELEASE) begin
            o_rsp_rdata  <= wr_q ? '0 : rx_sh;
            o_rsp_ta_err <= ta_err_q;
         end
      end
   end

endmodule

// File: tb/tb_vsc8541_smi_ctrl.sv
// tb/tb_vsc8541_smi_ctrl.sv - randomized frame-level checks of two controller configurations
module tb_vsc8541_smi_ctrl;

   localparam int NI = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_write [NI];
   logic [4:0]  req_phyad [NI];
   logic [4:0]  req_regad [NI];
   logic [15:0] req_wdata [NI];
   logic        rsp_valid [NI];
   logic [15:0] rsp_rdata [NI];
   logic        rsp_ta_err [NI];
   logic        busy [NI];
   logic        mdc [NI];
   logic        mdio_o [NI];
   logic        mdio_oe [NI];
   logic        mdio_i [NI];

   bit          t_write, t_present, nx_write, nx_present;
   logic [4:0]  t_phyad, t_regad, nx_phyad, nx_regad;
   logic [15:0] t_wdata, t_rdata, nx_wdata, nx_rdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      vsc8541_smi_ctrl #(
         .DIVISOR      (g == 0 ? 8 : 4),
         .PREAMBLE_LEN (g == 0 ? 32 : 0)
      ) u_dut (
         .clk          (clk),
         .i_reset_n    (rst_n),
         .i_req_valid  (req_valid[g]),
         .o_req_ready  (req_ready[g]),
         .i_req_write  (req_write[g]),
         .i_req_phyad  (req_phyad[g]),
         .i_req_regad  (req_regad[g]),
         .i_req_wdata  (req_wdata[g]),
         .o_rsp_valid  (rsp_valid[g]),
         .o_rsp_rdata  (rsp_rdata[g]),
         .o_rsp_ta_err (rsp_ta_err[g]),
         .o_busy       (busy[g]),
         .o_mdc        (mdc[g]),
         .o_mdio_o     (mdio_o[g]),
         .o_mdio_oe    (mdio_oe[g]),
         .i_mdio_i     (mdio_i[g])
      );
   end

   function automatic int div_of(input int idx);
      return (idx == 0) ? 8 : 4;
   endfunction

   function automatic int pre_of(input int idx);
      return (idx == 0) ? 32 : 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_mdc(input int idx);
      int half, run, runs, bad;
      logic prev;
      half = div_of(idx) / 2;
      prev = mdc[idx];
      run = 0; runs = 0; bad = 0;
      for (int c = 0; c < 8 * div_of(idx); c++) begin
         @(negedge clk);
         if (mdc[idx] === prev) run++;
         else begin
            if (runs > 0 && run != half) bad++;
            runs++;
            run = 1;
            prev = mdc[idx];
         end
      end
      check($sformatf("u%0d_mdc_duty", idx), bad, 0);
      check($sformatf("u%0d_mdc_toggles", idx), runs >= 8, 1);
   endtask

   // Presents t_* on unit idx and follows the whole frame from pin activity alone.
   task automatic run_txn(input int idx, input bit hold_next, input bit expect_imm);
      int          div, pre, n, nfall, nbits, rsp_cnt, fall_n_cyc, rsp_cyc, ready_busy, glitch, waited;
      bit          wr, present;
      logic [4:0]  pa, ra;
      logic [15:0] wd, rd, got_rdata;
      logic        got_ta, prev_mdc, cur_mdc, prev_fall;
      logic [1:0]  prev_pair, pair, end_pair;
      logic [31:0] tail;
      logic [63:0] exp_line, exp_oe, cap_line, cap_oe;

      div = div_of(idx); pre = pre_of(idx); n = pre + 32;
      wr = t_write; pa = t_phyad; ra = t_regad; wd = t_wdata; rd = t_rdata; present = t_present;
      tail = wr ? {2'b01, 2'b01, pa, ra, 2'b10, wd}
                : {2'b01, 2'b10, pa, ra, 1'b1, ~present, (present ? rd : 16'hFFFF)};
      exp_line = (((64'd1 << pre) - 64'd1) << 32) | {32'd0, tail};
      exp_oe   = wr ? ((64'd1 << n) - 64'd1) : (((64'd1 << (pre + 14)) - 64'd1) << 18);

      req_write[idx] = wr; req_phyad[idx] = pa; req_regad[idx] = ra; req_wdata[idx] = wd;
      req_valid[idx] = 1'b1;
      waited = 0;
      while (req_ready[idx] !== 1'b1 && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      if (expect_imm) check($sformatf("u%0d_b2b_accept_wait", idx), waited, 0);
      if (req_ready[idx] !== 1'b1) begin
         check($sformatf("u%0d_accept_timeout", idx), 0, 1);
         req_valid[idx] = 1'b0;
         return;
      end
      prev_mdc = mdc[idx];
      prev_pair = {mdio_o[idx], mdio_oe[idx]};
      prev_fall = 1'b0;
      @(negedge clk);
      check($sformatf("u%0d_busy_ready", idx), {busy[idx], req_ready[idx]}, 2'b10);
      if (hold_next) begin
         req_write[idx] = nx_write; req_phyad[idx] = nx_phyad;
         req_regad[idx] = nx_regad; req_wdata[idx] = nx_wdata;
      end else begin
         req_valid[idx] = 1'b0;
         req_write[idx] = 1'($urandom); req_phyad[idx] = 5'($urandom);
         req_regad[idx] = 5'($urandom); req_wdata[idx] = 16'($urandom);
      end

      nfall = 0; nbits = 0; rsp_cnt = 0; fall_n_cyc = -100; rsp_cyc = 0;
      ready_busy = 0; glitch = 0; cap_line = '0; cap_oe = '0;
      got_rdata = 'x; got_ta = 1'bx; end_pair = 'x;
      for (int c = 0; c < (n + 4) * div; c++) begin
         cur_mdc = mdc[idx];
         pair = {mdio_o[idx], mdio_oe[idx]};
         if (pair !== prev_pair && !prev_fall) glitch++;
         if (req_ready[idx] === 1'b1) ready_busy++;
         if (prev_mdc && !cur_mdc) begin
            if (nfall == n) fall_n_cyc = cyc;
            if (nfall < n && !wr && nfall >= pre + 14) mdio_i[idx] = exp_line[n - 1 - nfall];
            else mdio_i[idx] = 1'b1;
            nfall++;
         end
         if (!prev_mdc && cur_mdc && nfall >= 1 && nbits < n) begin
            cap_line[n - 1 - nbits] = mdio_oe[idx] ? mdio_o[idx] : mdio_i[idx];
            cap_oe[n - 1 - nbits] = mdio_oe[idx];
            nbits++;
         end
         if (rsp_valid[idx] === 1'b1) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            got_rdata = rsp_rdata[idx];
            got_ta = rsp_ta_err[idx];
            end_pair = pair;
            break;
         end
         prev_fall = prev_mdc && !cur_mdc;
         prev_mdc = cur_mdc;
         prev_pair = pair;
         @(negedge clk);
      end

      check($sformatf("u%0d_rsp_seen", idx), rsp_cnt, 1);
      check($sformatf("u%0d_frame_bits", idx), cap_line, exp_line);
      check($sformatf("u%0d_frame_oe", idx), cap_oe, exp_oe);
      check($sformatf("u%0d_rsp_latency", idx), rsp_cyc - fall_n_cyc, 2);
      check($sformatf("u%0d_rsp_rdata", idx), got_rdata, wr ? 16'h0 : (present ? rd : 16'hFFFF));
      check($sformatf("u%0d_rsp_ta_err", idx), got_ta, !wr && !present);
      check($sformatf("u%0d_released", idx), end_pair, 2'b10);
      check($sformatf("u%0d_drive_timing", idx), glitch, 0);
      check($sformatf("u%0d_ready_while_busy", idx), ready_busy, 0);
      mdio_i[idx] = 1'b1;
      @(negedge clk);
      check($sformatf("u%0d_rsp_one_cycle", idx), {rsp_valid[idx], req_ready[idx], busy[idx]}, 3'b010);
   endtask

   task automatic run_abort(input int idx);
      int waited, seen;
      req_write[idx] = 1'b1; req_phyad[idx] = 5'($urandom);
      req_regad[idx] = 5'($urandom); req_wdata[idx] = 16'($urandom);
      req_valid[idx] = 1'b1;
      waited = 0;
      while (req_ready[idx] !== 1'b1 && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      req_valid[idx] = 1'b0;
      repeat ((pre_of(idx) + 24) * div_of(idx)) @(negedge clk);
      check($sformatf("u%0d_abort_mid_data", idx), {busy[idx], mdio_oe[idx]}, 2'b11);
      rst_n = 1'b0;
      #1;
      check($sformatf("u%0d_abort_immediate", idx), {mdio_oe[idx], busy[idx], req_ready[idx]}, 3'b001);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid[idx] !== 1'b0) seen++;
      end
      rst_n = 1'b1;
      repeat (4 * div_of(idx)) begin
         @(negedge clk);
         if (rsp_valid[idx] !== 1'b0) seen++;
      end
      check($sformatf("u%0d_abort_no_rsp", idx), seen, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         req_valid[i] = 1'b0; req_write[i] = 1'b0; req_phyad[i] = '0;
         req_regad[i] = '0; req_wdata[i] = '0; mdio_i[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++)
         check($sformatf("u%0d_reset_state", i),
               {mdc[i], mdio_o[i], mdio_oe[i], rsp_valid[i], rsp_rdata[i], rsp_ta_err[i], busy[i], req_ready[i]},
               {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
      rst_n = 1'b1;
      @(negedge clk);
      check_mdc(0);
      check_mdc(1);

      t_write = 1; t_phyad = 5'h01; t_regad = 5'h1F; t_wdata = 16'h8001; t_rdata = 0; t_present = 1;
      run_txn(0, 0, 0);
      t_write = 0; t_phyad = 5'h03; t_regad = 5'h02; t_rdata = 16'hA5C3; t_present = 1;
      run_txn(0, 0, 0);
      t_write = 0; t_phyad = 5'h1E; t_regad = 5'h05; t_rdata = 16'h1234; t_present = 0;
      run_txn(0, 0, 0);

      t_write = 1; t_phyad = 5'h0A; t_regad = 5'h10; t_wdata = 16'h5A0F; t_present = 1;
      run_txn(1, 0, 0);
      t_write = 0; t_phyad = 5'h15; t_regad = 5'h0C; t_rdata = 16'h0F0F; t_present = 1;
      run_txn(1, 0, 0);

      t_write = 1; t_phyad = 5'h11; t_regad = 5'h04; t_wdata = 16'hC001; t_present = 1;
      nx_write = 0; nx_phyad = 5'h12; nx_regad = 5'h06; nx_wdata = 16'hFFFF; nx_rdata = 16'h7E81; nx_present = 1;
      run_txn(0, 1, 0);
      t_write = nx_write; t_phyad = nx_phyad; t_regad = nx_regad; t_wdata = nx_wdata;
      t_rdata = nx_rdata; t_present = nx_present;
      run_txn(0, 0, 1);

      run_abort(0);
      t_write = 0; t_phyad = 5'h07; t_regad = 5'h1A; t_rdata = 16'hBEEF; t_present = 1;
      run_txn(0, 0, 0);
      run_abort(1);
      t_write = 0; t_phyad = 5'h08; t_regad = 5'h01; t_rdata = 16'h8421; t_present = 1;
      run_txn(1, 0, 0);

      for (int k = 0; k < 10; k++) begin
         idx = (k < 3) ? 0 : 1;
         t_write = 1'($urandom); t_phyad = 5'($urandom); t_regad = 5'($urandom);
         t_wdata = 16'($urandom); t_rdata = 16'($urandom); t_present = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_txn(idx, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vsc8541_smi_ctrl.md
Name: vsc8541_smi_ctrl

Overview:
SMI (MDIO, IEEE 802.3 clause 22) transaction controller for the VSC8541 PHY management interface. It accepts single read/write requests over a valid/ready handshake and generates a free-running MDC from the system clock. It serialises preamble, start, opcode, PHY address, register address, turnaround and data onto a tristate MDIO, then returns read data or a write completion on a one-cycle response strobe. It sits between the register-access logic and the PHY pins.

Parameters:
DIVISOR, 100, system clocks per MDC period; legal range >= 4. MDC is high while the divider count < DIVISOR>>1.
PREAMBLE_LEN, 32, number of preamble '1' bits before start; legal range 0..32. 0 means preamble suppressed.

Ports:
clk  input  1  system clock
i_reset_n  input  1  reset, asynchronous, active-low
i_req_valid  input  1  request present
o_req_ready  output  1  controller can accept; high only in IDLE
i_req_write  input  1  1 = write, 0 = read
i_req_phyad  input  5  PHY address
i_req_regad  input  5  register address
i_req_wdata  input  16  write data
o_rsp_valid  output  1  one-cycle completion strobe
o_rsp_rdata  output  16  read data; 0 for writes
o_rsp_ta_err  output  1  read turnaround bit sampled 1 (no PHY responding)
o_busy  output  1  transaction in progress
o_mdc  output  1  management clock
o_mdio_o  output  1  MDIO drive value
o_mdio_oe  output  1  MDIO output enable
i_mdio_i  input  1  MDIO pin value

Behaviour:
- Reset: all state clears asynchronously on i_reset_n low. Reset values: divider count 0, o_mdc=1, o_mdio_oe=0, o_mdio_o=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_ta_err=0, o_busy=0, state IDLE, o_req_ready=1.
- Divider: the count runs 0..DIVISOR-1 and wraps. It runs free in every state. fall_stb is asserted when count == DIVISOR>>1. samp_stb is asserted when count == DIVISOR-1, which is the last cycle before MDC rises.
- All MDIO drive changes, o_mdio_o and o_mdio_oe, occur only on the cycle after fall_stb. All MDIO samples are taken on samp_stb.
- Handshake: a request is accepted when i_req_valid && o_req_ready. On accept, all request fields are latched; later input changes have no effect. Requests presented while not ready are ignored, not queued.
- States:
  - IDLE: ready=1, oe=0.
  - WAIT_EDGE: after accept, wait for fall_stb, then go to PREAMBLE, or to HDR if PREAMBLE_LEN=0.
  - PREAMBLE: drive 1 for PREAMBLE_LEN bit periods.
  - HDR: drive 14 bits MSB-first: ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0].
  - TA:
    - Write: drive 1 then 0.
    - Read: oe=0 for both bits; sample the second TA bit on samp_stb; a value of 1 sets the ta_err latch.
  - DATA:
    - Write: drive wdata[15:0] MSB-first.
    - Read: oe=0; shift i_mdio_i into rdata on each samp_stb, MSB-first.
  - RELEASE: at the fall_stb ending the last data bit, set oe=0 and o_mdio_o=1.
  - DONE: one cycle; o_rsp_valid=1 with o_rsp_rdata and o_rsp_ta_err valid; then go to IDLE.
- Response outputs hold their values until the next DONE. o_rsp_valid is high for exactly one cycle.
- Timing:
  - Bit count N = PREAMBLE_LEN + 32.
  - Bit k (0-based) is driven from fall_stb_k to fall_stb_{k+1}, DIVISOR cycles apart.
  - o_rsp_valid asserts 2 cycles after fall_stb_N.
  - The earliest next accept is the cycle after o_rsp_valid.
- o_busy = (state != IDLE).
- A read with ta_err still completes the full 16 data bits. Data is whatever is sampled, typically 0xFFFF with the pull-up.
- Reset mid-frame: oe drops immediately, no response is issued, and the controller returns to IDLE.
- Bit counter is 6 bits wide. State transitions occur only on fall_stb, apart from accept and DONE.

Decomposition:
- Package vsc8541_smi_pkg contains:
  - state enum (IDLE, WAIT_EDGE, PREAMBLE, HDR, TA, DATA, RELEASE, DONE)
  - constants SMI_ST=2'b01, SMI_OP_WR=2'b01, SMI_OP_RD=2'b10, SMI_TA_WR=2'b10
  - widths PHYAD_W=5, REGAD_W=5, DATA_W=16, HDR_BITS=14
- Sub-module vsc8541_smi_mdc_strobe: divider producing o_mdc, fall_stb and samp_stb, with async active-low reset. The FSM and shift registers live in the top module.

Test Plan:
- Write with DIVISOR=8, PREAMBLE_LEN=32, phyad=0x01, regad=0x1F, wdata=0x8001 → MDIO sampled at MDC rises reads 32×1, 01 01 00001 11111 10, then 1000000000000001. oe is high for all 64 bits. o_rsp_valid pulses once with rdata=0 at the specified cycle.
- Read with a PHY model driving TA0=0 then 0xA5C3 → oe=0 from TA onward, o_rsp_rdata=0xA5C3, o_rsp_ta_err=0.
- Read with no PHY (pull-up, i_mdio_i=1) → o_rsp_ta_err=1, o_rsp_rdata=0xFFFF, response still issued.
- PREAMBLE_LEN=0 and DIVISOR=4 → the frame starts directly with 01 and spans exactly 32 bit periods. MDC is high for 2 cycles and low for 2. Response arrives 2 cycles after the 32nd subsequent fall_stb.
- Back-to-back: i_req_valid held high with a second request → the second is accepted the cycle after o_rsp_valid. Requests raised during busy see ready=0 and are not accepted.
- Drop i_reset_n mid-DATA of a write → o_mdio_oe=0 and o_busy=0 immediately, no o_rsp_valid. After release, a new read completes correctly.
